// File: rtl/clk_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl_pkg
// Brief    : Shared types and sizing helpers for the clock-gate sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package clk_gate_ctrl_pkg;

    typedef enum logic [2:0] {
        ON        = 3'd0,
        DRAIN     = 3'd1,
        OFF       = 3'd2,
        WAKE_PEND = 3'd3,
        WAKE      = 3'd4
    } cg_state_e;

    // One counter serves both the idle hysteresis and the wake settle time.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gate_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl_fsm
// Brief    : Per-domain gate/wake state machine with registered enable decode.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl_fsm
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_g,
    input  logic      i_w,
    input  logic      i_grant,
    output cg_state_e o_state,
    output logic      o_en,
    output logic      o_ready,
    output logic      o_gated
);

    localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wake_last = CNT_W'(WAKE_CYCLES - 1);

    cg_state_e        r_state;
    cg_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_en;
    logic             w_ready;
    logic             w_gated;
    logic             r_en;
    logic             r_ready;
    logic             r_gated;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ON;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ON: begin
                if (i_g) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (!i_g) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_idle_last) begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            OFF: begin
                if (i_w) begin
                    w_state_nxt = WAKE_PEND;
                end
            end
            WAKE_PEND: begin
                // A grant wins even if the request has just dropped.
                if (i_grant) begin
                    w_state_nxt = WAKE;
                    w_cnt_nxt   = '0;
                end else if (!i_w) begin
                    w_state_nxt = OFF;
                end
            end
            WAKE: begin
                if (r_cnt == c_wake_last) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ON;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_en    = 1'b0;
        w_ready = 1'b0;
        w_gated = 1'b0;
        case (r_state)
            ON, DRAIN: begin
                w_en    = 1'b1;
                w_ready = 1'b1;
            end
            OFF, WAKE_PEND: begin
                w_gated = 1'b1;
            end
            WAKE: begin
                w_en = 1'b1;
            end
            default: begin
                w_en    = 1'b1;
                w_ready = 1'b1;
            end
        endcase
    end

    // Glitch-free enable into the gating cell: decode is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en    <= 1'b1;
            r_ready <= 1'b1;
            r_gated <= 1'b0;
        end else begin
            r_en    <= w_en;
            r_ready <= w_ready;
            r_gated <= w_gated;
        end
    end

    assign o_state = r_state;
    assign o_en    = r_en;
    assign o_ready = r_ready;
    assign o_gated = r_gated;

endmodule
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Per-domain clock-gate sequencer with rate-limited round-robin wake.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int N_DOMAINS   = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4,
    parameter int MAX_WAKE    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 test_en_i,
    input  logic [N_DOMAINS-1:0] autogate_i,
    input  logic [N_DOMAINS-1:0] idle_i,
    input  logic [N_DOMAINS-1:0] req_i,
    output logic [N_DOMAINS-1:0] en_o,
    output logic [N_DOMAINS-1:0] ready_o,
    output logic [N_DOMAINS-1:0] gated_o
);

    localparam int c_cnt_w = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam int c_idx_w = idx_width(N_DOMAINS);

    logic [N_DOMAINS-1:0] w_g;
    logic [N_DOMAINS-1:0] w_w;
    logic [N_DOMAINS-1:0] w_pend;
    logic [N_DOMAINS-1:0] w_grant;
    cg_state_e            w_state [N_DOMAINS];
    int                   w_active;
    logic [c_idx_w-1:0]   r_rr;
    logic [c_idx_w-1:0]   w_rr_nxt;

    assign w_g = autogate_i & idle_i & ~req_i & {N_DOMAINS{~test_en_i}};
    assign w_w = req_i | ~autogate_i | {N_DOMAINS{test_en_i}};

    // Slot usage comes from the state registers, so a domain leaving WAKE
    // only frees its slot for the following cycle's grant.
    always_comb begin
        w_active = 0;
        w_pend   = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            w_pend[i] = (w_state[i] == WAKE_PEND);
            if (w_state[i] == WAKE) begin
                w_active = w_active + 1;
            end
        end
    end

    always_comb begin : p_arb
        int                 n_gr;
        int                 free;
        logic [c_idx_w-1:0] idx;
        w_grant  = '0;
        w_rr_nxt = r_rr;
        n_gr     = 0;
        free     = MAX_WAKE - w_active;
        idx      = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            idx = c_idx_w'((int'(r_rr) + i) % N_DOMAINS);
            if (w_pend[idx] && (n_gr < free)) begin
                w_grant[idx] = 1'b1;
                n_gr         = n_gr + 1;
                w_rr_nxt     = c_idx_w'((int'(idx) + 1) % N_DOMAINS);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else begin
            r_rr <= w_rr_nxt;
        end
    end

    for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_dom
        clk_gate_ctrl_fsm #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES),
            .CNT_W       (c_cnt_w)
        ) u_fsm (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_g     (w_g[gi]),
            .i_w     (w_w[gi]),
            .i_grant (w_grant[gi]),
            .o_state (w_state[gi]),
            .o_en    (en_o[gi]),
            .o_ready (ready_o[gi]),
            .o_gated (gated_o[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Self-checking bench: cycle scoreboard plus directed timing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int N    = 4;
    localparam int IDLE = 16;
    localparam int WAKE = 4;
    localparam int MAXW = 1;

    localparam int S_ON   = 0;
    localparam int S_DRN  = 1;
    localparam int S_OFF  = 2;
    localparam int S_PEND = 3;
    localparam int S_WAKE = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         test_en;
    logic [N-1:0] autogate;
    logic [N-1:0] idle;
    logic [N-1:0] req;
    logic [N-1:0] en;
    logic [N-1:0] ready;
    logic [N-1:0] gated;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3*N-1:0] sb_q[$];
    int             m_st [N];
    int             m_cnt[N];
    int             m_rr;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .N_DOMAINS   (N),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .MAX_WAKE    (MAXW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .test_en_i  (test_en),
        .autogate_i (autogate),
        .idle_i     (idle),
        .req_i      (req),
        .en_o       (en),
        .ready_o    (ready),
        .gated_o    (gated)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i]  = S_ON;
            m_cnt[i] = 0;
        end
        m_rr = 0;
    endtask

    // Reference behaviour: expected outputs after this edge are the decode
    // of the state held before it.
    task automatic model_step();
        logic [N-1:0] e, r, gt;
        bit           gr[N];
        int           active, granted, base, idx;
        bit           gv, wv;
        if (rst) begin
            model_reset();
            sb_q.push_back({{N{1'b1}}, {N{1'b1}}, {N{1'b0}}});
            return;
        end
        active = 0;
        for (int i = 0; i < N; i++) begin
            e[i]  = (m_st[i] == S_ON) || (m_st[i] == S_DRN) || (m_st[i] == S_WAKE);
            r[i]  = (m_st[i] == S_ON) || (m_st[i] == S_DRN);
            gt[i] = (m_st[i] == S_OFF) || (m_st[i] == S_PEND);
            gr[i] = 1'b0;
            if (m_st[i] == S_WAKE) active++;
        end
        sb_q.push_back({e, r, gt});
        granted = 0;
        base    = m_rr;
        for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (m_st[idx] == S_PEND && granted < MAXW - active) begin
                gr[idx] = 1'b1;
                granted++;
                m_rr = (idx + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            gv = autogate[i] & idle[i] & ~req[i] & ~test_en;
            wv = req[i] | ~autogate[i] | test_en;
            case (m_st[i])
                S_ON:   if (gv) begin m_st[i] = S_DRN; m_cnt[i] = 0; end
                S_DRN: begin
                    if (!gv) begin m_st[i] = S_ON; m_cnt[i] = 0; end
                    else if (m_cnt[i] == IDLE - 1) begin m_st[i] = S_OFF; m_cnt[i] = 0; end
                    else m_cnt[i]++;
                end
                S_OFF:  if (wv) m_st[i] = S_PEND;
                S_PEND: begin
                    if (gr[i]) begin m_st[i] = S_WAKE; m_cnt[i] = 0; end
                    else if (!wv) m_st[i] = S_OFF;
                end
                default: begin
                    if (m_cnt[i] == WAKE - 1) begin m_st[i] = S_ON; m_cnt[i] = 0; end
                    else m_cnt[i]++;
                end
            endcase
        end
    endtask

    task automatic tick();
        logic [3*N-1:0] exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp = sb_q.pop_front();
        chk_eq("sb_out", {20'd0, en, ready, gated}, {20'd0, exp});
    endtask

    function automatic logic [N-1:0] pick(input int which);
        return (which == 0) ? en : ((which == 1) ? ready : gated);
    endfunction

    task automatic wait_sig(input int which, input logic [N-1:0] mask,
                            input logic [N-1:0] val, input int limit, output int n);
        n = 0;
        while (((pick(which) & mask) != val) && (n < limit)) begin
            tick();
            n++;
        end
        if ((pick(which) & mask) != val) chk_eq("wait_timeout", pick(which) & mask, val);
    endtask

    task automatic async_rst(input string tag);
        #2 rst = 1'b1;
        #1;
        chk_eq({tag, "_en"},    en,    {N{1'b1}});
        chk_eq({tag, "_ready"}, ready, {N{1'b1}});
        chk_eq({tag, "_gated"}, gated, {N{1'b0}});
        model_reset();
        sb_q.delete();
        @(negedge clk);
        tick();
        rst = 1'b0;
    endtask

    task automatic arb_round(input string tag, input int first);
        logic [N-1:0] prev, rises;
        int           ord[N];
        int           at[N];
        int           nrise, multi;
        nrise = 0;
        multi = 0;
        for (int k = 0; k < N; k++) begin ord[k] = -1; at[k] = -1; end
        prev = en;
        req  = {N{1'b1}};
        for (int t = 1; t <= 40; t++) begin
            tick();
            rises = en & ~prev;
            prev  = en;
            if ($countones(rises) > 1) multi++;
            for (int d = 0; d < N; d++) begin
                if (rises[d] && nrise < N) begin
                    ord[nrise] = d;
                    at[nrise]  = t;
                    nrise++;
                end
            end
            if (en == {N{1'b1}}) break;
        end
        chk_eq({tag, "_nrise"}, nrise, N);
        chk_eq({tag, "_multi"}, multi, 0);
        for (int k = 0; k < N; k++) begin
            chk_eq({tag, "_order"}, ord[k], (first + k) % N);
            // Sample edge, grant edge, then registered en: first rise on tick 3.
            chk_eq({tag, "_time"}, at[k], 3 + k * (WAKE + 1));
        end
    endtask

    initial begin
        int n, bad;
        rst      = 1'b1;
        test_en  = 1'b0;
        autogate = '0;
        idle     = '0;
        req      = '0;
        model_reset();
        tick();
        tick();
        chk_eq("reset_en",    en,    4'hF);
        chk_eq("reset_ready", ready, 4'hF);
        chk_eq("reset_gated", gated, 4'h0);
        rst = 1'b0;

        // Idle hysteresis, interrupted at cycle 10 then restarted from zero
        autogate = 4'h1;
        idle     = 4'h1;
        repeat (10) tick();
        idle = 4'h0;
        tick();
        chk_eq("drain_abort_en", en[0], 1);
        tick();
        idle = 4'h1;
        wait_sig(0, 4'h1, 4'h0, 40, n);
        chk_eq("idle_gate_lat", n, IDLE + 2);
        chk_eq("idle_gated", gated, 4'h1);

        // Single-cycle wake pulse; WAKE continues after req drops
        req = 4'h1;
        tick();
        req = 4'h0;
        wait_sig(0, 4'h1, 4'h1, 20, n);
        chk_eq("wake_en_lat", n + 1, 3);
        wait_sig(1, 4'h1, 4'h1, 20, n);
        chk_eq("wake_ready_lat", n, WAKE);

        // Reset while domain 0 is in WAKE, then while all domains drain
        wait_sig(2, 4'h1, 4'h1, 40, n);
        req = 4'h1;
        tick();
        req = 4'h0;
        tick();
        tick();
        chk_eq("midwake_en", en[0], 1);
        autogate = 4'hF;
        idle     = 4'hF;
        async_rst("rst_wake");
        repeat (5) tick();
        async_rst("rst_drain");
        wait_sig(0, 4'hF, 4'h0, 40, n);
        chk_eq("post_rst_gate_lat", n, IDLE + 2);

        // Round-robin wake from pointer 0
        arb_round("arb0", 0);
        wait_sig(1, 4'hF, 4'hF, 40, n);
        req = 4'h0;
        wait_sig(2, 4'hF, 4'hF, 60, n);
        // Wake only 0 and 1 to leave the pointer at 2
        req = 4'h3;
        wait_sig(1, 4'h3, 4'h3, 40, n);
        req = 4'h0;
        wait_sig(2, 4'hF, 4'hF, 60, n);
        arb_round("arb2", 2);
        wait_sig(1, 4'hF, 4'hF, 40, n);

        // Test mode with domains 0,1 OFF and 2,3 in DRAIN
        req  = 4'h0;
        idle = 4'h3;
        wait_sig(2, 4'hF, 4'h3, 60, n);
        idle = 4'hF;
        repeat (5) tick();
        test_en = 1'b1;
        wait_sig(1, 4'hF, 4'hF, 40, n);
        chk_eq("test_wake_bound", n <= 4 * (WAKE + 1), 1);
        bad = 0;
        repeat (40) begin
            tick();
            if (en != 4'hF) bad++;
        end
        chk_eq("test_no_gate", bad, 0);
        test_en = 1'b0;

        // Clearing autogate wakes the domain and keeps it on despite idle
        wait_sig(2, 4'hF, 4'hF, 60, n);
        chk_eq("ag_all_off", gated, 4'hF);
        autogate = 4'hB;
        wait_sig(1, 4'h4, 4'h4, 20, n);
        chk_eq("ag_wake_lat", n, 3 + WAKE);
        bad = 0;
        repeat (100) begin
            tick();
            if (!en[2] || !ready[2]) bad++;
        end
        chk_eq("ag_stay_on", bad, 0);
        chk_eq("ag_others_off", gated, 4'hB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
